// File: rtl/hi_reader_amp_slicer.sv
// HF reader amplitude slicer: noise-floor tracker, hysteresis slicer and run-length
// encoder feeding a 4-deep (last, level, length) event FIFO. All state moves on the falling clock edge.
module hi_reader_amp_slicer #(
    parameter logic [13:0] THRESH_HI_OFS = 14'd64,
    parameter logic [13:0] THRESH_LO_OFS = 14'd32,
    parameter logic [7:0]  TIMEOUT       = 8'd32
) (
    input  logic        ck_1356meg,
    input  logic        reset_n,
    input  logic        enable,
    input  logic        amp_valid,
    input  logic [13:0] amp,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [9:0]  out_data,
    output logic        overflow,
    output logic        active
);

    typedef enum logic {S_IDLE, S_ACTIVE} state_t;

    state_t       state_q, state_d;
    logic [13:0]  floor_q, floor_d;
    logic         level_q, level_d;
    logic [7:0]   run_q, run_d;
    logic         ev_vld_q, ev_vld_d;
    logic [9:0]   ev_data_q, ev_data_d;

    logic [9:0]   fifo_q [4];
    logic [1:0]   rd_ptr_q, rd_ptr_d;
    logic [1:0]   wr_ptr_q, wr_ptr_d;
    logic [2:0]   cnt_q, cnt_d;
    logic         ovf_q, ovf_d;

    logic [14:0]        hi_sum, lo_sum;
    logic [13:0]        hi_th, lo_th;
    logic signed [14:0] diff, step;
    logic               lvl_new;
    logic [7:0]         run_inc;
    logic               pop, full, do_push;

    // Thresholds come from the floor as it was before this sample's update.
    assign hi_sum  = {1'b0, floor_q} + {1'b0, THRESH_HI_OFS};
    assign lo_sum  = {1'b0, floor_q} + {1'b0, THRESH_LO_OFS};
    assign hi_th   = hi_sum[14] ? 14'h3FFF : hi_sum[13:0];
    assign lo_th   = lo_sum[14] ? 14'h3FFF : lo_sum[13:0];
    assign diff    = $signed({1'b0, amp}) - $signed({1'b0, floor_q});
    assign step    = diff >>> 3;
    assign lvl_new = (amp >= hi_th) ? 1'b1 : ((amp < lo_th) ? 1'b0 : level_q);
    assign run_inc = (run_q == 8'hFF) ? run_q : run_q + 8'd1;

    always_comb begin
        state_d   = state_q;
        floor_d   = floor_q;
        level_d   = level_q;
        run_d     = run_q;
        ev_vld_d  = 1'b0;
        ev_data_d = ev_data_q;
        if (!enable) begin
            state_d = S_IDLE;
            level_d = 1'b0;
            run_d   = 8'd0;
        end else if (amp_valid) begin
            level_d = lvl_new;
            case (state_q)
                S_IDLE: begin
                    floor_d = floor_q + step[13:0];
                    if (lvl_new) begin
                        state_d = S_ACTIVE;
                        run_d   = 8'd1;
                    end
                end
                S_ACTIVE: begin
                    if (lvl_new != level_q) begin
                        ev_vld_d  = 1'b1;
                        ev_data_d = {1'b0, level_q, run_q};
                        run_d     = 8'd1;
                    end else if (!level_q && (run_inc >= TIMEOUT)) begin
                        ev_vld_d  = 1'b1;
                        ev_data_d = {1'b1, 1'b0, TIMEOUT};
                        state_d   = S_IDLE;
                        run_d     = 8'd0;
                    end else begin
                        run_d = run_inc;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign full    = (cnt_q == 3'd4);
    assign pop     = out_valid & out_ready;
    assign do_push = ev_vld_q & (~full | pop);

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        cnt_d    = cnt_q;
        ovf_d    = ovf_q;
        if (!enable) begin
            rd_ptr_d = 2'd0;
            wr_ptr_d = 2'd0;
            cnt_d    = 3'd0;
            ovf_d    = 1'b0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 2'd1;
            if (pop)     rd_ptr_d = rd_ptr_q + 2'd1;
            case ({do_push, pop})
                2'b10:   cnt_d = cnt_q + 3'd1;
                2'b01:   cnt_d = cnt_q - 3'd1;
                default: cnt_d = cnt_q;
            endcase
            if (ev_vld_q && full && !pop) ovf_d = 1'b1;
        end
    end

    always_ff @(negedge ck_1356meg or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            floor_q   <= 14'd0;
            level_q   <= 1'b0;
            run_q     <= 8'd0;
            ev_vld_q  <= 1'b0;
            ev_data_q <= 10'd0;
            rd_ptr_q  <= 2'd0;
            wr_ptr_q  <= 2'd0;
            cnt_q     <= 3'd0;
            ovf_q     <= 1'b0;
            for (int i = 0; i < 4; i++) fifo_q[i] <= 10'd0;
        end else begin
            state_q   <= state_d;
            floor_q   <= floor_d;
            level_q   <= level_d;
            run_q     <= run_d;
            ev_vld_q  <= ev_vld_d;
            ev_data_q <= ev_data_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            cnt_q     <= cnt_d;
            ovf_q     <= ovf_d;
            if (enable && do_push) fifo_q[wr_ptr_q] <= ev_data_q;
        end
    end

    assign out_valid = (cnt_q != 3'd0);
    assign out_data  = out_valid ? fifo_q[rd_ptr_q] : 10'd0;
    assign overflow  = ovf_q;
    assign active    = (state_q == S_ACTIVE);

endmodule

// File: tb/tb_hi_reader_amp_slicer.sv
// Scoreboard bench for hi_reader_amp_slicer: a behavioural model predicts events,
// a free-running monitor pops and compares them whenever the DUT hands one over.
module tb_hi_reader_amp_slicer;

    localparam int HI_OFS = 64;
    localparam int LO_OFS = 32;
    localparam int TO     = 32;

    logic        ck_1356meg = 1'b0;
    logic        reset_n    = 1'b0;
    logic        enable     = 1'b1;
    logic        amp_valid  = 1'b0;
    logic [13:0] amp        = 14'd0;
    logic        out_ready  = 1'b1;
    logic        out_valid;
    logic [9:0]  out_data;
    logic        overflow;
    logic        active;

    hi_reader_amp_slicer #(
        .THRESH_HI_OFS(14'(HI_OFS)),
        .THRESH_LO_OFS(14'(LO_OFS)),
        .TIMEOUT      (8'(TO))
    ) dut (
        .ck_1356meg(ck_1356meg),
        .reset_n   (reset_n),
        .enable    (enable),
        .amp_valid (amp_valid),
        .amp       (amp),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .overflow  (overflow),
        .active    (active)
    );

    always #5 ck_1356meg = ~ck_1356meg;

    int checks = 0;
    int errors = 0;
    int pops   = 0;

    // Behavioural model: floor, slicer level, response state, current run, FIFO fill.
    int         m_floor = 0;
    int         m_level = 0;
    int         m_active = 0;
    int         m_run = 0;
    int         m_cnt = 0;
    int         m_ovf = 0;
    logic [9:0] exp_q[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    function automatic int fdiv8(input int d);
        if (d >= 0) return d / 8;
        return -((-d + 7) / 8);
    endfunction

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic void model_emit(input logic [9:0] ev, input bit rdy_at_push);
        if (m_cnt >= 4 && !rdy_at_push) m_ovf = 1;
        else begin
            exp_q.push_back(ev);
            m_cnt++;
        end
    endfunction

    function automatic void model_sample(input int a, input bit rdy_at_push);
        int hi, lo, nl;
        hi = imin(m_floor + HI_OFS, 16383);
        lo = imin(m_floor + LO_OFS, 16383);
        nl = (a >= hi) ? 1 : ((a < lo) ? 0 : m_level);
        if (m_active == 0) begin
            m_floor = m_floor + fdiv8(a - m_floor);
            if (nl == 1) begin
                m_active = 1;
                m_run    = 1;
            end
        end else if (nl != m_level) begin
            model_emit({1'b0, (m_level == 1), 8'(m_run)}, rdy_at_push);
            m_run = 1;
        end else begin
            m_run = imin(m_run + 1, 255);
            if (nl == 0 && m_run >= TO) begin
                model_emit({2'b10, 8'(TO)}, rdy_at_push);
                m_active = 0;
                m_run    = 0;
            end
        end
        m_level = nl;
    endfunction

    function automatic void model_clear(input bit with_floor);
        exp_q.delete();
        m_cnt = 0; m_ovf = 0; m_active = 0; m_level = 0; m_run = 0;
        if (with_floor) m_floor = 0;
    endfunction

    // One strobe: valid for one falling edge, out_ready takes rdy_after at the push edge.
    task automatic send(input int a, input bit rdy_after);
        model_sample(a, rdy_after);
        @(posedge ck_1356meg);
        amp_valid = 1'b1;
        amp       = 14'(a);
        @(posedge ck_1356meg);
        amp_valid = 1'b0;
        out_ready = rdy_after;
        @(posedge ck_1356meg);
        #1;
        chk("active", int'(active), m_active);
        chk("overflow", int'(overflow), m_ovf);
    endtask

    task automatic send_n(input int a, input int n);
        for (int i = 0; i < n; i++) send(a, out_ready);
    endtask

    task automatic converge(input int target);
        for (int i = 0; i < 120; i++) send(imin(target, m_floor + 40), out_ready);
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge ck_1356meg);
        #1;
    endtask

    task automatic flush();
        @(posedge ck_1356meg);
        enable = 1'b0;
        @(posedge ck_1356meg);
        enable = 1'b1;
        model_clear(1'b0);
        #1;
        chk("flush_out_valid", int'(out_valid), 0);
        chk("flush_overflow", int'(overflow), 0);
        chk("flush_active", int'(active), 0);
    endtask

    // Monitor: a pop happens at the next falling edge whenever valid & ready are seen here.
    always @(posedge ck_1356meg) begin
        #1;
        if (reset_n && enable && out_valid && out_ready) begin
            pops++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_event: got 0x%0h, expected no event at %0t", out_data, $time);
            end else begin
                logic [9:0] e;
                e = exp_q.pop_front();
                m_cnt--;
                if (out_data !== e) begin
                    errors++;
                    $display("FAIL event: got 0x%0h, expected 0x%0h at %0t", out_data, e, $time);
                end
            end
        end
    end

    initial begin
        int hi_a, lo_a, p0;

        // Reset held with inputs toggling.
        reset_n = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge ck_1356meg);
            amp_valid = i[0];
            amp       = 14'(9000 + i);
            enable    = ~i[1];
            out_ready = i[0];
        end
        #1;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_overflow", int'(overflow), 0);
        chk("rst_active", int'(active), 0);
        chk("rst_out_data", int'(out_data), 0);
        amp_valid = 1'b0; enable = 1'b1; out_ready = 1'b1; amp = 14'd0;
        @(posedge ck_1356meg);
        reset_n = 1'b1;
        wait_cycles(8);
        chk("idle_out_valid", int'(out_valid), 0);
        chk("idle_active", int'(active), 0);

        // Floor converges toward 100 without crossing the high threshold.
        converge(100);
        wait_cycles(4);
        chk("conv_out_valid", int'(out_valid), 0);

        // Basic response.
        send_n(200, 5); send_n(100, 3); send_n(200, 2); send_n(100, 32);
        wait_cycles(4);

        // Hysteresis: mid-band sample in IDLE, then mid-band samples inside a high run.
        send(140, 1'b1);
        send(200, 1'b1); send_n(140, 4); send_n(100, TO);
        wait_cycles(4);

        // Run-length saturation.
        send_n(200, 300); send_n(100, TO);
        wait_cycles(4);

        // Backpressure: five events with no consumer, then drain.
        hi_a = m_floor + 100; lo_a = m_floor;
        out_ready = 1'b0;
        send(hi_a, 1'b0);
        for (int i = 0; i < 5; i++) send(i[0] ? hi_a : lo_a, 1'b0);
        chk("bp_overflow_set", int'(overflow), 1);
        p0 = pops;
        out_ready = 1'b1;
        wait_cycles(10);
        chk("bp_pops", pops - p0, 4);
        chk("bp_drained", int'(out_valid), 0);
        out_ready = 1'b0;
        flush();

        // Push and pop on a full FIFO in the same cycle.
        send(hi_a, 1'b0);
        for (int i = 0; i < 4; i++) send(i[0] ? hi_a : lo_a, 1'b0);
        p0 = pops;
        send(lo_a, 1'b1);
        wait_cycles(10);
        chk("full_pushpop_overflow", int'(overflow), 0);
        chk("full_pushpop_pops", pops - p0, 5);
        out_ready = 1'b0;
        flush();

        // Asynchronous reset in the middle of a response.
        send(hi_a, 1'b0); send(lo_a, 1'b0); send(hi_a, 1'b0);
        @(posedge ck_1356meg);
        #3;
        reset_n = 1'b0;
        model_clear(1'b1);
        #1;
        chk("midrst_out_valid", int'(out_valid), 0);
        chk("midrst_active", int'(active), 0);
        chk("midrst_overflow", int'(overflow), 0);
        @(posedge ck_1356meg);
        reset_n   = 1'b1;
        out_ready = 1'b1;
        wait_cycles(10);
        chk("postrst_out_valid", int'(out_valid), 0);

        // Randomized traffic with a live consumer.
        converge(100);
        for (int i = 0; i < 400; i++) begin
            int r, a;
            r = int'($urandom_range(0, 9));
            if (r < 4)      a = m_floor - 20 + int'($urandom_range(0, 60));
            else if (r < 8) a = m_floor + int'($urandom_range(60, 160));
            else            a = m_floor + int'($urandom_range(25, 75));
            if (a < 0) a = 0;
            if (a > 16383) a = 16383;
            send(a, 1'b1);
        end
        send_n(m_floor > 200 ? m_floor - 200 : 0, TO + 2);

        for (int i = 0; i < 50 && exp_q.size() != 0; i++) wait_cycles(1);
        chk("scoreboard_empty", exp_q.size(), 0);
        chk("final_out_valid", int'(out_valid), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
